team_09_gpio_arbiter: RTL and testbench

Shares the team_09 user GPIO output bank (the 34 checked pins, mprj_io[37:5] and mprj_io[0], packed as bits [33:1] and [0]) among NREQ internal requesters. It uses a round-robin arbiter with a bounded hold time and a one-cycle hi-Z turnaround between owners. The block sits between the team_09 functional units and the user-project io_out/io_oeb nets. gpio outputs are registered, and no two requesters ever drive in the same cycle.

---
 rtl/team_09_gpio_arbiter.sv | 168 ++++++++++++++++
 tb/tb_team_09_gpio_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/team_09_gpio_arbiter.sv
// -----------------------------------------------------------------------------
// team_09_gpio_arbiter
//
// Purpose:
//   Shares the team_09 user GPIO output bank among NREQ internal requesters.
//   Round-robin arbitration with a bounded hold time (MAX_HOLD grant cycles
//   when someone else is waiting) and a one-cycle hi-Z turnaround (RELEASE)
//   between owners. Pad data and enables are registered. At most one
//   requester ever drives the pads in a given cycle.
//
// Ports:
//   wb_clk_i       in   1           system clock
//   wb_rst_i       in   1           synchronous reset, active high
//   en             in   1           arbiter enable; low releases and blocks grants
//   req            in   NREQ        per-requester level request
//   req_out        in   NREQ*WIDTH  per-requester pad data, slice [i*WIDTH +: WIDTH]
//   req_oeb        in   NREQ*WIDTH  per-requester active-low enables, same slicing
//   gnt            out  NREQ        one-hot grant, registered
//   owner          out  OW          index of the current/last owner
//   busy           out  1           high while in GRANT or RELEASE
//   timeout_pulse  out  1           one-cycle pulse when MAX_HOLD pre-empts a grant
//   gpio_out       out  WIDTH       registered pad data
//   gpio_oeb       out  WIDTH       registered active-low pad enables
// -----------------------------------------------------------------------------
module team_09_gpio_arbiter #(
   parameter  int NREQ     = 4,
   parameter  int WIDTH    = 34,
   parameter  int MAX_HOLD = 256,
   parameter  int HOLD_W   = 8,
   localparam int OW       = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic                  wb_clk_i,
   input  logic                  wb_rst_i,
   input  logic                  en,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*WIDTH-1:0] req_out,
   input  logic [NREQ*WIDTH-1:0] req_oeb,
   output logic [NREQ-1:0]       gnt,
   output logic [OW-1:0]         owner,
   output logic                  busy,
   output logic                  timeout_pulse,
   output logic [WIDTH-1:0]      gpio_out,
   output logic [WIDTH-1:0]      gpio_oeb
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_GRANT   = 2'd1,
      ST_RELEASE = 2'd2
   } state_t;

   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

   state_t            state, state_next;
   logic [NREQ-1:0]   gnt_next;
   logic [OW-1:0]     owner_next;
   logic [HOLD_W-1:0] hold_cnt, hold_next;
   logic              pulse_next;
   logic [WIDTH-1:0]  out_next, oeb_next;

   logic [2*NREQ-1:0] req_dbl;
   logic [OW-1:0]     pick;
   logic [NREQ-1:0]   pick_onehot;
   logic [WIDTH-1:0]  sel_out, sel_oeb;
   logic              owner_drop, other_req, hold_last;

   // Round-robin search: rotate the request vector so that bit 0 is the
   // requester right after the last owner, then take the lowest set bit.
   // The loop runs downwards so the nearest requester is the last to win.
   always_comb begin
      // NOTE: every variable assigned in an always_comb gets a default first,
      // so no path leaves it unassigned and no latch is inferred.
      req_dbl     = {req, req} >> (int'(owner) + 1);
      pick        = owner;
      pick_onehot = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (req_dbl[k]) begin
            pick = OW'((int'(owner) + 1 + k) % NREQ);
         end
      end
      for (int i = 0; i < NREQ; i++) begin
         pick_onehot[i] = (int'(pick) == i);
      end
   end

   // Pad source mux gated by the registered grant itself: a requester whose
   // gnt bit is low can never reach the pads, whatever owner holds.
   always_comb begin
      sel_out = '0;
      sel_oeb = '1;
      for (int i = 0; i < NREQ; i++) begin
         sel_out = sel_out | (req_out[i*WIDTH +: WIDTH] & {WIDTH{gnt[i]}});
         sel_oeb = sel_oeb & (req_oeb[i*WIDTH +: WIDTH] | {WIDTH{~gnt[i]}});
      end
   end

   assign owner_drop = ~|(req & gnt);
   assign other_req  = |(req & ~gnt);
   assign hold_last  = (hold_cnt == HOLD_LAST);
   assign busy       = (state != ST_IDLE);

   // Next-state and next-output logic. Pads default to hi-Z and only carry
   // owner data on a GRANT edge that does not exit, so the exit edge itself
   // already floats the pads.
   always_comb begin
      state_next = state;
      gnt_next   = gnt;
      owner_next = owner;
      hold_next  = hold_cnt;
      pulse_next = 1'b0;
      out_next   = '0;
      oeb_next   = '1;
      case (state)
         ST_IDLE: begin
            if (en && (|req)) begin
               state_next = ST_GRANT;
               gnt_next   = pick_onehot;
               owner_next = pick;
               hold_next  = '0;
            end
         end
         ST_GRANT: begin
            if (!en || owner_drop || (hold_last && other_req)) begin
               state_next = ST_RELEASE;
               gnt_next   = '0;
               // A req drop or en low takes precedence over the timeout.
               pulse_next = en && !owner_drop;
            end else begin
               out_next = sel_out;
               oeb_next = sel_oeb;
               if (!hold_last) begin
                  hold_next = hold_cnt + HOLD_W'(1);
               end
            end
         end
         ST_RELEASE: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
            gnt_next   = '0;
         end
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      if (wb_rst_i) begin
         state         <= ST_IDLE;
         gnt           <= '0;
         owner         <= OW'(NREQ - 1);
         hold_cnt      <= '0;
         timeout_pulse <= 1'b0;
         gpio_out      <= '0;
         gpio_oeb      <= '1;
      end else begin
         state         <= state_next;
         gnt           <= gnt_next;
         owner         <= owner_next;
         hold_cnt      <= hold_next;
         timeout_pulse <= pulse_next;
         gpio_out      <= out_next;
         gpio_oeb      <= oeb_next;
      end
   end

endmodule

// File: tb/tb_team_09_gpio_arbiter.sv
// -----------------------------------------------------------------------------
// tb_team_09_gpio_arbiter
//
// Purpose:
//   Self-checking bench for team_09_gpio_arbiter (NREQ=4, WIDTH=34,
//   MAX_HOLD=8). A behavioural model tracks who holds the bus, for how long,
//   and whether a turnaround cycle is pending, and predicts every output
//   after each clock edge. Directed scenarios add fixed expectations.
//
// Ports: none (top-level bench).
// -----------------------------------------------------------------------------
module tb_team_09_gpio_arbiter;

   localparam int NREQ     = 4;
   localparam int WIDTH    = 34;
   localparam int MAX_HOLD = 8;
   localparam int HOLD_W   = 3;
   localparam logic [WIDTH-1:0] HIZ = '1;

   logic                  clk = 1'b0;
   logic                  wb_rst_i = 1'b1;
   logic                  en = 1'b0;
   logic [NREQ-1:0]       req = '0;
   logic [NREQ*WIDTH-1:0] req_out = '0;
   logic [NREQ*WIDTH-1:0] req_oeb = '1;
   logic [NREQ-1:0]       gnt;
   logic [1:0]            owner;
   logic                  busy;
   logic                  timeout_pulse;
   logic [WIDTH-1:0]      gpio_out;
   logic [WIDTH-1:0]      gpio_oeb;

   always #5 clk = ~clk;

   team_09_gpio_arbiter #(
      .NREQ(NREQ), .WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD), .HOLD_W(HOLD_W)
   ) dut (
      .wb_clk_i(clk), .wb_rst_i(wb_rst_i), .en(en), .req(req),
      .req_out(req_out), .req_oeb(req_oeb), .gnt(gnt), .owner(owner),
      .busy(busy), .timeout_pulse(timeout_pulse),
      .gpio_out(gpio_out), .gpio_oeb(gpio_oeb)
   );

   int n_pass  = 0;
   int n_total = 0;

   // Reference model: holding / cooling flags, owner index and grant age.
   bit               m_held  = 1'b0;
   bit               m_cool  = 1'b0;
   int               m_owner = NREQ - 1;
   int               m_age   = 0;
   logic [NREQ-1:0]  e_gnt   = '0;
   logic [1:0]       e_owner = 2'd3;
   logic             e_busy  = 1'b0;
   logic             e_pulse = 1'b0;
   logic [WIDTH-1:0] e_out   = '0;
   logic [WIDTH-1:0] e_oeb   = '1;

   // Advance one clock: update the model from the inputs sampled at the edge,
   // then return on the falling edge where outputs are compared.
   task automatic step();
      bit drop, other;
      int c;
      @(posedge clk);
      if (wb_rst_i) begin
         m_held = 1'b0; m_cool = 1'b0; m_owner = NREQ - 1; m_age = 0;
         e_gnt = '0; e_pulse = 1'b0; e_out = '0; e_oeb = HIZ;
      end else begin
         e_pulse = 1'b0; e_out = '0; e_oeb = HIZ;
         if (m_held) begin
            drop  = !req[m_owner];
            other = 1'b0;
            for (int j = 0; j < NREQ; j++) if (j != m_owner && req[j]) other = 1'b1;
            if (!en || drop || (m_age == MAX_HOLD - 1 && other)) begin
               m_held = 1'b0; m_cool = 1'b1; e_gnt = '0;
               e_pulse = en && !drop;
            end else begin
               e_out = req_out[m_owner*WIDTH +: WIDTH];
               e_oeb = req_oeb[m_owner*WIDTH +: WIDTH];
               if (m_age < MAX_HOLD - 1) m_age++;
            end
         end else if (m_cool) begin
            m_cool = 1'b0;
         end else if (en && req != '0) begin
            c = m_owner;
            for (int k = NREQ; k >= 1; k--) if (req[(m_owner + k) % NREQ]) c = (m_owner + k) % NREQ;
            m_owner = c; m_held = 1'b1; m_age = 0;
            e_gnt = NREQ'(1 << c);
         end
      end
      e_owner = 2'(m_owner);
      e_busy  = m_held || m_cool;
      @(negedge clk);
   endtask

   task automatic rand_data();
      logic [159:0] t;
      t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      req_out = t[NREQ*WIDTH-1:0];
      t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      req_oeb = t[NREQ*WIDTH-1:0];
   endtask

   task automatic reset_dut();
      wb_rst_i = 1'b1; step(); wb_rst_i = 1'b0;
   endtask

   task automatic test_reset();
      wb_rst_i = 1'b1; en = 1'b1; req = 4'b1111; rand_data();
      step();
      n_total++;
      if (gpio_oeb !== 34'h3_FFFF_FFFF || gnt !== 4'b0000 || owner !== 2'd3 || busy !== 1'b0 || timeout_pulse !== 1'b0 || gpio_out !== '0)
         $display("FAIL reset_values gnt=%b owner=%0d busy=%b pulse=%b out=%h oeb=%h want gnt=0000 owner=3 busy=0 pulse=0 out=0 oeb=3ffffffff",
                  gnt, owner, busy, timeout_pulse, gpio_out, gpio_oeb);
      else n_pass++;
      wb_rst_i = 1'b0;
      req_out[WIDTH-1:0] = 34'h2_AAAA_AAAA;
      req_oeb[WIDTH-1:0] = 34'h0_0000_FFFF;
      step();
      n_total++;
      if (gnt !== 4'b0001) $display("FAIL first_grant gnt=%b want 0001", gnt);
      else n_pass++;
      step();
      n_total++;
      if (gpio_out !== 34'h2_AAAA_AAAA || gpio_oeb !== 34'h0_0000_FFFF)
         $display("FAIL first_data out=%h oeb=%h want 2aaaaaaaa/00000ffff", gpio_out, gpio_oeb);
      else n_pass++;
   endtask

   task automatic test_round_robin();
      int order[$];
      int exp_order[5] = '{0, 1, 2, 3, 0};
      int age, gaps, idx;
      logic [NREQ-1:0] prev_gnt;
      reset_dut();
      en = 1'b1; req = 4'b1111; age = 0; gaps = 0; idx = 0; prev_gnt = '0;
      for (int cyc = 0; cyc < 80 && order.size() < 5; cyc++) begin
         rand_data();
         step();
         n_total++;
         if ({gnt, owner, busy, timeout_pulse, gpio_out, gpio_oeb} !== {e_gnt, e_owner, e_busy, e_pulse, e_out, e_oeb})
            $display("FAIL rr_model t=%0t gnt=%b/%b owner=%0d/%0d busy=%b/%b pulse=%b/%b out=%h/%h oeb=%h/%h (got/want)",
                     $time, gnt, e_gnt, owner, e_owner, busy, e_busy, timeout_pulse, e_pulse, gpio_out, e_out, gpio_oeb, e_oeb);
         else n_pass++;
         if (gnt != '0 && prev_gnt == '0) begin
            idx = $clog2(gnt);
            order.push_back(idx);
            if (order.size() > 1) begin
               n_total++;
               if (gaps !== 1) $display("FAIL rr_gap_cycles got %0d want 1", gaps);
               else n_pass++;
            end
            gaps = 0; age = 0; req = 4'b1111;
         end
         if (gnt == '0 && busy) begin
            gaps++;
            n_total++;
            if (gpio_oeb !== HIZ) $display("FAIL rr_gap_hiz oeb=%h want %h", gpio_oeb, HIZ);
            else n_pass++;
         end
         if (gnt != '0) begin
            age++;
            if (age == 5) req[idx] = 1'b0;
         end
         prev_gnt = gnt;
      end
      n_total++;
      if (order.size() != 5) $display("FAIL rr_grant_count got %0d want 5", order.size());
      else n_pass++;
      for (int i = 0; i < order.size() && i < 5; i++) begin
         n_total++;
         if (order[i] != exp_order[i]) $display("FAIL rr_order[%0d] got %0d want %0d", i, order[i], exp_order[i]);
         else n_pass++;
      end
   endtask

   task automatic test_timeout();
      int own0, pulses, own_long;
      bit saw2;
      reset_dut();
      en = 1'b1; req = 4'b0001;
      step();
      own0 = (gnt == 4'b0001) ? 1 : 0; pulses = 0; saw2 = 1'b0;
      for (int n = 1; n <= 16; n++) begin
         if (n == 2) req[2] = 1'b1;
         rand_data();
         step();
         n_total++;
         if ({gnt, owner, busy, timeout_pulse, gpio_out, gpio_oeb} !== {e_gnt, e_owner, e_busy, e_pulse, e_out, e_oeb})
            $display("FAIL to_model t=%0t gnt=%b/%b owner=%0d/%0d busy=%b/%b pulse=%b/%b out=%h/%h oeb=%h/%h (got/want)",
                     $time, gnt, e_gnt, owner, e_owner, busy, e_busy, timeout_pulse, e_pulse, gpio_out, e_out, gpio_oeb, e_oeb);
         else n_pass++;
         if (gnt == 4'b0001) own0++;
         if (timeout_pulse) pulses++;
         if (gnt == 4'b0100) saw2 = 1'b1;
      end
      n_total++;
      if (own0 !== MAX_HOLD) $display("FAIL to_hold_cycles got %0d want %0d", own0, MAX_HOLD);
      else n_pass++;
      n_total++;
      if (pulses !== 1) $display("FAIL to_pulse_count got %0d want 1", pulses);
      else n_pass++;
      n_total++;
      if (saw2 !== 1'b1) $display("FAIL to_next_owner got %b want 1 (gnt 0100 seen)", saw2);
      else n_pass++;

      reset_dut();
      req = 4'b0001; pulses = 0; own_long = 0;
      for (int n = 0; n < 55; n++) begin
         rand_data();
         step();
         if (gnt == 4'b0001) own_long++;
         if (timeout_pulse) pulses++;
      end
      n_total++;
      if (own_long !== 55 || pulses !== 0)
         $display("FAIL to_sole_hold own=%0d pulses=%0d want 55/0", own_long, pulses);
      else n_pass++;
   endtask

   task automatic test_en_low();
      int grants;
      reset_dut();
      en = 1'b1; req = 4'b1111;
      step(); step(); step();
      en = 1'b0;
      step();
      n_total++;
      if (gnt !== 4'b0000 || busy !== 1'b1 || gpio_oeb !== HIZ)
         $display("FAIL en_release gnt=%b busy=%b oeb=%h want 0000/1/%h", gnt, busy, gpio_oeb, HIZ);
      else n_pass++;
      step();
      n_total++;
      if (busy !== 1'b0) $display("FAIL en_idle busy=%b want 0", busy);
      else n_pass++;
      grants = 0;
      for (int n = 0; n < 10; n++) begin
         step();
         if (gnt != '0) grants++;
         n_total++;
         if ({gnt, owner, busy, timeout_pulse, gpio_out, gpio_oeb} !== {e_gnt, e_owner, e_busy, e_pulse, e_out, e_oeb})
            $display("FAIL en_model t=%0t gnt=%b/%b owner=%0d/%0d busy=%b/%b (got/want)", $time, gnt, e_gnt, owner, e_owner, busy, e_busy);
         else n_pass++;
      end
      n_total++;
      if (grants !== 0) $display("FAIL en_no_grant got %0d grant cycles want 0", grants);
      else n_pass++;
   endtask

   task automatic test_reset_mid_grant();
      reset_dut();
      en = 1'b1; req = 4'b0100;
      step(); step(); step();
      wb_rst_i = 1'b1;
      step();
      n_total++;
      if (gnt !== 4'b0000 || owner !== 2'd3 || gpio_oeb !== HIZ || busy !== 1'b0)
         $display("FAIL rst_mid gnt=%b owner=%0d oeb=%h busy=%b want 0000/3/%h/0", gnt, owner, gpio_oeb, busy, HIZ);
      else n_pass++;
      wb_rst_i = 1'b0; req = 4'b0101;
      step();
      n_total++;
      if (gnt !== 4'b0001) $display("FAIL rst_mid_regrant gnt=%b want 0001", gnt);
      else n_pass++;
   endtask

   task automatic test_skip();
      int waited, g3;
      reset_dut();
      en = 1'b1; req = 4'b0010;
      step(); step();
      req = 4'b0000;
      waited = 0;
      step();
      while (busy && waited < 10) begin step(); waited++; end
      n_total++;
      if (busy !== 1'b0) $display("FAIL skip_idle_wait busy=%b want 0", busy);
      else n_pass++;
      req = 4'b0011;
      step();
      n_total++;
      if (gnt !== 4'b0001) $display("FAIL skip_wrap gnt=%b want 0001", gnt);
      else n_pass++;
      g3 = 0;
      for (int n = 0; n < 12; n++) begin
         req = (n == 1) ? 4'b1001 : (n < 6) ? 4'b0001 : 4'b0000;
         rand_data();
         step();
         if (gnt[3]) g3++;
         n_total++;
         if ({gnt, owner, busy, timeout_pulse, gpio_out, gpio_oeb} !== {e_gnt, e_owner, e_busy, e_pulse, e_out, e_oeb})
            $display("FAIL skip_model t=%0t gnt=%b/%b owner=%0d/%0d busy=%b/%b out=%h/%h (got/want)", $time, gnt, e_gnt, owner, e_owner, busy, e_busy, gpio_out, e_out);
         else n_pass++;
      end
      n_total++;
      if (g3 !== 0) $display("FAIL skip_pulse_req got %0d grant cycles for 3 want 0", g3);
      else n_pass++;
   endtask

   task automatic test_random();
      reset_dut();
      for (int n = 0; n < 500; n++) begin
         if ($urandom_range(0, 5) == 0) req = NREQ'($urandom_range(0, 15));
         en       = ($urandom_range(0, 19) != 0);
         wb_rst_i = ($urandom_range(0, 149) == 0);
         rand_data();
         step();
         n_total++;
         if ({gnt, owner, busy, timeout_pulse, gpio_out, gpio_oeb} !== {e_gnt, e_owner, e_busy, e_pulse, e_out, e_oeb} || !$onehot0(gnt))
            $display("FAIL rand_model t=%0t gnt=%b/%b owner=%0d/%0d busy=%b/%b pulse=%b/%b out=%h/%h oeb=%h/%h (got/want)",
                     $time, gnt, e_gnt, owner, e_owner, busy, e_busy, timeout_pulse, e_pulse, gpio_out, e_out, gpio_oeb, e_oeb);
         else n_pass++;
      end
      wb_rst_i = 1'b0;
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_round_robin();
      test_timeout();
      test_en_low();
      test_reset_mid_grant();
      test_skip();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
